// File: rtl/bram_port_arbiter_if.sv
// Bus bundle between requesters, the BRAM port arbiter and one BRAM port.
//   req_valid/req_we/req_lock : per-requester request, write flag, lock request
//   req_addr/req_wdata        : per-requester address/data, slice i = [i*W +: W]
//   req_ready                 : one-hot grant back to requesters
//   rsp_valid/rsp_data        : one-hot read-response strobe and read data
//   mem_ce/mem_we/mem_a/mem_d : BRAM port command
//   mem_q                     : BRAM read data, one cycle after a read command
// Modports: slave = arbiter view, master = requester/memory (environment) view.
interface bram_port_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 10,
    parameter int unsigned DW   = 16
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_we;
    logic [NREQ-1:0]    req_lock;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    rsp_valid;
    logic [DW-1:0]      rsp_data;
    logic               mem_ce;
    logic               mem_we;
    logic [AW-1:0]      mem_a;
    logic [DW-1:0]      mem_d;
    logic [DW-1:0]      mem_q;

    modport slave (
        input  req_valid, req_we, req_lock, req_addr, req_wdata, mem_q,
        output req_ready, rsp_valid, rsp_data, mem_ce, mem_we, mem_a, mem_d
    );

    modport master (
        output req_valid, req_we, req_lock, req_addr, req_wdata, mem_q,
        input  req_ready, rsp_valid, rsp_data, mem_ce, mem_we, mem_a, mem_d
    );
endinterface

// File: rtl/bram_port_arbiter.sv
// Arbitrates NREQ requesters onto a single synchronous BRAM port.
// Grant is combinational; a read accepted in cycle N returns its data in N+1.
// A requester may hold the port across cycles with req_lock.
// Optional feature macro BRAM_ARB_RR_EN: round-robin arbitration with a
// priority pointer; when undefined, fixed priority (lowest index wins).
// Ports:
//   CLK  : clock, rising edge
//   RSTN : asynchronous active-low reset
//   bus  : bram_port_arbiter_if.slave (request, response and BRAM signals)
module bram_port_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned AW   = 10,
    parameter int unsigned DW   = 16
) (
    input  logic                   CLK,
    input  logic                   RSTN,
    bram_port_arbiter_if.slave     bus
);
    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic            rd_pend_q, rd_pend_d;
    logic [PW-1:0]   rd_idx_q, rd_idx_d;
`ifdef BRAM_ARB_RR_EN
    logic [PW-1:0]   ptr_q, ptr_d;
    int unsigned     rr_idx;
`endif

    logic [NREQ-1:0] grant_c;
    logic [PW-1:0]   gidx_c;
    logic            accept_c;

    // Grant selection; forced idle while reset is asserted.
    always_comb begin
        grant_c  = '0;
        gidx_c   = '0;
        accept_c = 1'b0;
`ifdef BRAM_ARB_RR_EN
        rr_idx   = 0;
`endif
        if (!RSTN) begin
            accept_c = 1'b0;
        end else if (state_q == ST_LOCKED) begin
            if (bus.req_valid[owner_q]) begin
                accept_c = 1'b1;
                gidx_c   = owner_q;
            end
        end else begin
`ifdef BRAM_ARB_RR_EN
            // Scan from farthest to nearest so the first requester after ptr wins.
            for (int unsigned k = NREQ; k >= 1; k--) begin
                rr_idx = (32'(ptr_q) + k) % NREQ;
                if (bus.req_valid[PW'(rr_idx)]) begin
                    accept_c = 1'b1;
                    gidx_c   = PW'(rr_idx);
                end
            end
`else
            // Scan downwards so the lowest valid index wins.
            for (int i = int'(NREQ) - 1; i >= 0; i--) begin
                if (bus.req_valid[i]) begin
                    accept_c = 1'b1;
                    gidx_c   = PW'(i);
                end
            end
`endif
        end
        if (accept_c) begin
            grant_c[gidx_c] = 1'b1;
        end
    end

    // BRAM command and response outputs; everything zero when idle.
    always_comb begin
        bus.req_ready = grant_c;
        bus.mem_ce    = accept_c;
        bus.mem_we    = 1'b0;
        bus.mem_a     = '0;
        bus.mem_d     = '0;
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        if (accept_c) begin
            bus.mem_we = bus.req_we[gidx_c];
            bus.mem_a  = bus.req_addr[32'(gidx_c) * AW +: AW];
            bus.mem_d  = bus.req_wdata[32'(gidx_c) * DW +: DW];
        end
        if (rd_pend_q) begin
            bus.rsp_valid[rd_idx_q] = 1'b1;
            bus.rsp_data            = bus.mem_q;
        end
    end

    // Next-state: lock ownership, pending read response, priority pointer.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rd_pend_d = accept_c & ~bus.req_we[gidx_c];
        rd_idx_d  = gidx_c;
`ifdef BRAM_ARB_RR_EN
        ptr_d     = ptr_q;
        if ((state_q == ST_OPEN) && accept_c) begin
            ptr_d = gidx_c;
        end
`endif
        case (state_q)
            ST_OPEN: begin
                if (accept_c && bus.req_lock[gidx_c]) begin
                    state_d = ST_LOCKED;
                    owner_d = gidx_c;
                end
            end
            ST_LOCKED: begin
                // Owner idling or releasing the lock on its beat reopens the port.
                if (!bus.req_valid[owner_q] || !bus.req_lock[owner_q]) begin
                    state_d = ST_OPEN;
                end
            end
            default: state_d = ST_OPEN;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= ST_OPEN;
            owner_q   <= '0;
            rd_pend_q <= 1'b0;
            rd_idx_q  <= '0;
`ifdef BRAM_ARB_RR_EN
            ptr_q     <= PW'(NREQ - 1);
`endif
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rd_pend_q <= rd_pend_d;
            rd_idx_q  <= rd_idx_d;
`ifdef BRAM_ARB_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed testbench for bram_port_arbiter with a behavioural BRAM.
// Expected grants follow the arbitration mode selected by BRAM_ARB_RR_EN.
module tb_bram_port_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned AW   = 10;
    localparam int unsigned DW   = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bram_port_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();

    bram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
        .CLK  (clk),
        .RSTN (rst_n),
        .bus  (bus.slave)
    );

    // Synchronous single-cycle-read BRAM
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_ce) begin
            if (bus.mem_we) mem[bus.mem_a] <= bus.mem_d;
            else            bus.mem_q <= mem[bus.mem_a];
        end
    end

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_lock  = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic set_req(input int i, input logic we, input logic lock,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]          = 1'b1;
        bus.req_we[i]             = we;
        bus.req_lock[i]           = lock;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_reqs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        clear_reqs();
        bus.req_valid = 4'hF;
        #2;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rst_ready: got %b exp 0000", bus.req_ready); end
        checks++; if (bus.mem_ce !== 1'b0) begin errors++; $display("FAIL rst_mem_ce: got %b exp 0", bus.mem_ce); end
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rst_rsp_valid: got %b exp 0000", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 16'h0000) begin errors++; $display("FAIL rst_rsp_data: got %h exp 0000", bus.rsp_data); end
        @(negedge clk);
        @(negedge clk);
        clear_reqs();
        rst_n = 1'b1;
    endtask

    // Write then read the same address back-to-back from requester 1.
    task automatic test_write_read();
        set_req(1, 1'b1, 1'b0, 10'd5, 16'h1234);
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL wr_grant: got %b exp 0010", bus.req_ready); end
        checks++; if ({bus.mem_ce, bus.mem_we} !== 2'b11) begin errors++; $display("FAIL wr_ce_we: got %b exp 11", {bus.mem_ce, bus.mem_we}); end
        checks++; if (bus.mem_a !== 10'd5) begin errors++; $display("FAIL wr_addr: got %h exp 005", bus.mem_a); end
        checks++; if (bus.mem_d !== 16'h1234) begin errors++; $display("FAIL wr_data: got %h exp 1234", bus.mem_d); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL wr_no_rsp: got %b exp 0000", bus.rsp_valid); end
        clear_reqs();
        set_req(1, 1'b0, 1'b0, 10'd5, 16'h0);
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL rd_grant: got %b exp 0010", bus.req_ready); end
        checks++; if ({bus.mem_ce, bus.mem_we} !== 2'b10) begin errors++; $display("FAIL rd_ce_we: got %b exp 10", {bus.mem_ce, bus.mem_we}); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b0010) begin errors++; $display("FAIL rd_rsp_valid: got %b exp 0010", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 16'h1234) begin errors++; $display("FAIL rd_rsp_data: got %h exp 1234", bus.rsp_data); end
        clear_reqs();
    endtask

    // Fill addresses 0..3 with A000+i via requester 0.
    task automatic test_preload();
        for (int i = 0; i < 4; i++) begin
            clear_reqs();
            set_req(0, 1'b1, 1'b0, 10'(i), 16'hA000 + 16'(i));
            #1;
            checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL preload_grant%0d: got %b exp 0001", i, bus.req_ready); end
            @(negedge clk);
        end
        clear_reqs();
    endtask

    // All four requesters read continuously from reset.
    task automatic test_round_robin();
        int e;
        int prev;
        apply_reset();
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 10'(i), 16'h0);
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                checks++; if (bus.rsp_valid !== 4'(1 << prev)) begin errors++; $display("FAIL rr_rsp_valid%0d: got %b exp %b", k, bus.rsp_valid, 4'(1 << prev)); end
                checks++; if (bus.rsp_data !== 16'hA000 + 16'(prev)) begin errors++; $display("FAIL rr_rsp_data%0d: got %h exp %h", k, bus.rsp_data, 16'hA000 + 16'(prev)); end
            end
`ifdef BRAM_ARB_RR_EN
            e = k % 4;
`else
            e = 0;
`endif
            #1;
            checks++; if (bus.req_ready !== 4'(1 << e)) begin errors++; $display("FAIL rr_grant%0d: got %b exp %b", k, bus.req_ready, 4'(1 << e)); end
            prev = e;
            @(negedge clk);
        end
        checks++; if (bus.rsp_valid !== 4'(1 << prev)) begin errors++; $display("FAIL rr_rsp_last: got %b exp %b", bus.rsp_valid, 4'(1 << prev)); end
        clear_reqs();
    endtask

    // Requester 2 locks the port for three write beats.
    task automatic test_lock();
        logic [3:0]  e_g;
        logic [15:0] e_d;
        apply_reset();
        set_req(2, 1'b1, 1'b1, 10'h3FF, 16'hBEEF);
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL lock_beat1: got %b exp 0100", bus.req_ready); end
        checks++; if (bus.mem_a !== 10'h3FF || bus.mem_d !== 16'hBEEF || bus.mem_we !== 1'b1) begin errors++; $display("FAIL lock_cmd: got a=%h d=%h we=%b exp a=3ff d=beef we=1", bus.mem_a, bus.mem_d, bus.mem_we); end
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 10'd0, 16'h0);
        set_req(1, 1'b0, 1'b0, 10'd1, 16'h0);
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL lock_beat2: got %b exp 0100", bus.req_ready); end
        @(negedge clk);
        bus.req_lock[2] = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL lock_beat3: got %b exp 0100", bus.req_ready); end
        @(negedge clk);
        bus.req_valid[2] = 1'b0;
        set_req(3, 1'b0, 1'b0, 10'h3FF, 16'h0);
`ifdef BRAM_ARB_RR_EN
        e_g = 4'b1000; e_d = 16'hBEEF;
`else
        e_g = 4'b0001; e_d = 16'hA000;
`endif
        #1;
        checks++; if (bus.req_ready !== e_g) begin errors++; $display("FAIL lock_after: got %b exp %b", bus.req_ready, e_g); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== e_g || bus.rsp_data !== e_d) begin errors++; $display("FAIL lock_after_rsp: got %b/%h exp %b/%h", bus.rsp_valid, bus.rsp_data, e_g, e_d); end
        clear_reqs();
        #1;
        checks++; if (bus.req_ready !== 4'b0000 || bus.mem_ce !== 1'b0 || bus.mem_a !== 10'd0) begin errors++; $display("FAIL idle: got rdy=%b ce=%b a=%h exp 0000/0/000", bus.req_ready, bus.mem_ce, bus.mem_a); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b0000 || bus.rsp_data !== 16'h0) begin errors++; $display("FAIL idle_rsp: got %b/%h exp 0000/0000", bus.rsp_valid, bus.rsp_data); end
    endtask

    // Locked owner drops valid for a cycle: no grant, port reopens.
    task automatic test_lock_drop();
        logic [3:0] e_g;
        clear_reqs();
        set_req(1, 1'b0, 1'b1, 10'd1, 16'h0);
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL drop_lock_grant: got %b exp 0010", bus.req_ready); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b0010 || bus.rsp_data !== 16'hA001) begin errors++; $display("FAIL drop_rsp: got %b/%h exp 0010/a001", bus.rsp_valid, bus.rsp_data); end
        clear_reqs();
        set_req(0, 1'b0, 1'b0, 10'd0, 16'h0);
        set_req(2, 1'b0, 1'b0, 10'd2, 16'h0);
        #1;
        checks++; if (bus.req_ready !== 4'b0000 || bus.mem_ce !== 1'b0) begin errors++; $display("FAIL drop_nogrant: got %b ce=%b exp 0000 ce=0", bus.req_ready, bus.mem_ce); end
        @(negedge clk);
`ifdef BRAM_ARB_RR_EN
        e_g = 4'b0100;
`else
        e_g = 4'b0001;
`endif
        #1;
        checks++; if (bus.req_ready !== e_g) begin errors++; $display("FAIL drop_reopen: got %b exp %b", bus.req_ready, e_g); end
        @(negedge clk);
        clear_reqs();
    endtask

    // Reset pulse right after a read grant discards the response.
    task automatic test_reset_mid();
        set_req(2, 1'b0, 1'b0, 10'd2, 16'h0);
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL rm_grant: got %b exp 0100", bus.req_ready); end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.rsp_valid !== 4'b0000 || bus.rsp_data !== 16'h0) begin errors++; $display("FAIL rm_rsp: got %b/%h exp 0000/0000", bus.rsp_valid, bus.rsp_data); end
        checks++; if (bus.req_ready !== 4'b0000 || bus.mem_ce !== 1'b0) begin errors++; $display("FAIL rm_ready: got %b ce=%b exp 0000 ce=0", bus.req_ready, bus.mem_ce); end
        clear_reqs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL rm_rsp_after: got %b exp 0000", bus.rsp_valid); end
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b0, 10'(i), 16'h0);
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL rm_first_grant: got %b exp 0001", bus.req_ready); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 4'b0001 || bus.rsp_data !== 16'hA000) begin errors++; $display("FAIL rm_first_rsp: got %b/%h exp 0001/a000", bus.rsp_valid, bus.rsp_data); end
        clear_reqs();
    endtask

    // Requesters 0 and 3 request continuously.
    task automatic test_fixed_pair();
        logic [3:0] e_g;
        set_req(0, 1'b0, 1'b0, 10'd0, 16'h0);
        set_req(3, 1'b0, 1'b0, 10'd3, 16'h0);
        for (int k = 0; k < 4; k++) begin
`ifdef BRAM_ARB_RR_EN
            e_g = (k % 2 == 0) ? 4'b1000 : 4'b0001;
`else
            e_g = 4'b0001;
`endif
            #1;
            checks++; if (bus.req_ready !== e_g) begin errors++; $display("FAIL pair_grant%0d: got %b exp %b", k, bus.req_ready, e_g); end
            @(negedge clk);
        end
        clear_reqs();
    endtask

    initial begin
        clear_reqs();
        test_reset();
        test_write_read();
        test_preload();
        test_round_robin();
        test_lock();
        test_lock_drop();
        test_reset_mid();
        test_fixed_pair();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter AW, default 10, giving the memory address width.
REQ-003 The block SHALL have parameter DW, default 16, giving the memory data width.
REQ-004 Port CLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port RSTN, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port req_valid, input, NREQ bits: per-requester access request.
REQ-007 Port req_we, input, NREQ bits: per-requester write flag (1 = write, 0 = read).
REQ-008 Port req_lock, input, NREQ bits: per-requester request to keep ownership of the port for the next cycle.
REQ-009 Port req_addr, input, NREQ*AW bits: per-requester address; requester i uses slice [i*AW +: AW].
REQ-010 Port req_wdata, input, NREQ*DW bits: per-requester write data; requester i uses slice [i*DW +: DW].
REQ-011 Port req_ready, output, NREQ bits: one-hot grant; a request is accepted when req_valid[i] and req_ready[i] are both 1.
REQ-012 Port rsp_valid, output, NREQ bits: one-hot read-response strobe.
REQ-013 Port rsp_data, output, DW bits: read data.
REQ-014 Ports mem_ce (1), mem_we (1), mem_a (AW), mem_d (DW): outputs driving one port of a synchronous single-cycle-read BRAM.
REQ-015 Port mem_q, input, DW bits: BRAM read data, valid one cycle after the ce/read edge.

Function
REQ-016 Grant (req_ready) SHALL be combinational from req_valid, the owner state and the priority pointer; at most one bit is set.
REQ-017 If no req_valid bit is set, req_ready SHALL be 0 and mem_ce SHALL be 0.
REQ-018 On acceptance by requester g, mem_ce = 1 and mem_we = req_we[g], with mem_a and mem_d taken from slice g, all in the same cycle.
REQ-019 When mem_ce = 0, mem_a, mem_d and mem_we SHALL be 0.
REQ-020 When a read is accepted in cycle N, rsp_valid[g] SHALL be 1 in cycle N+1, with rsp_data = mem_q.
REQ-021 rsp_valid SHALL be 0 for writes and in idle cycles; rsp_data SHALL be 0 whenever rsp_valid = 0.
REQ-022 Arbitration order SHALL start at index (ptr+1) mod NREQ, wrap around, and grant the first requester with req_valid set.
REQ-023 After every acceptance, ptr SHALL be set to the granted index.
REQ-024 Lock handling uses two states, OPEN and LOCKED(owner o).
  - OPEN -> LOCKED(g): on an accepted request with req_lock[g] = 1.
  - While LOCKED: only requester o can be granted; req_ready[o] = req_valid[o].
  - LOCKED -> OPEN: on an accepted beat with req_lock[o] = 0, or in any cycle where req_valid[o] = 0 (no grant in that cycle).
REQ-025 While LOCKED, ptr SHALL be unchanged, so that fairness resumes after the owner when the port returns to OPEN.
REQ-026 Read-then-write back-to-back by one requester SHALL be legal every cycle: the response from cycle N and a new access in cycle N+1 coexist.
REQ-027 The block SHALL not reorder or buffer requests; a requester that is not granted holds its request unchanged (requester obligation).

Reset
REQ-028 With RSTN = 0, the following SHALL hold asynchronously:
  - ptr = NREQ-1, so index 0 has first priority;
  - state = OPEN;
  - rsp_valid = 0 and rsp_data = 0;
  - req_ready = 0 and mem_ce = 0.
REQ-029 If reset is asserted in the cycle after a read grant, the pending response SHALL be discarded (no rsp_valid after release).
REQ-030 The first grant SHALL be possible in the first clock edge after RSTN rises.

Configuration
REQ-031 With macro BRAM_ARB_RR_EN defined, arbitration SHALL be round-robin per REQ-022/023.
REQ-032 Without BRAM_ARB_RR_EN, arbitration SHALL be fixed priority (lowest index wins) and ptr SHALL be absent; lock behaviour is unchanged.

Verification
REQ-033 With RR enabled, all 4 requesters hold reads to addresses 0..3 continuously -> grants go 0,1,2,3,0, and each rsp_valid[i] follows its grant by exactly 1 cycle with the correct data.
REQ-034 Requester 2 writes 0xBEEF to address 0x3FF with req_lock=1 for 3 beats while requesters 0 and 1 also request -> only 2 is granted for 3 cycles; after its lock drops, requester 3 or 0 (order from ptr=2) is granted next.
REQ-035 The locked owner drops req_valid for one cycle while others request -> no grant in that cycle, state returns to OPEN, and the next cycle grants by round-robin.
REQ-036 Requester 1 writes 0x1234 at address 5 in cycle N and reads address 5 in cycle N+1 -> rsp_valid[1] in cycle N+2 with rsp_data = 0x1234.
REQ-037 RSTN pulses low asynchronously mid-cycle right after a read grant -> rsp_valid stays 0, and after release the first grant goes to requester 0.
REQ-038 Without BRAM_ARB_RR_EN, requesters 0 and 3 request continuously -> requester 0 is granted every cycle.
